// File: rtl/mac_sequencer.sv
// mac_sequencer
//
// Control FSM for a MAC unit datapath. It runs one dot-product job of `len`
// operand pairs. For each job it pulses the accumulator clear, then accepts
// operand pairs over a valid/ready handshake and drives the A/B operand
// register load enable. Accumulate enables are delayed by MUL_LAT cycles to
// line up with the multiplier output. Once the pipeline has drained, it holds
// res_valid until the consumer takes the result. This block has no
// arithmetic datapath of its own.
//
// Parameters
//   CNT_W    width of len / count
//   MUL_LAT  operand-load edge to valid product at accumulator input, 1..4
//
// Ports
//   CLK        clock, rising edge
//   R          synchronous active-high reset
//   start      start a job (honoured in IDLE only)
//   len        operand pair count, sampled when start is honoured
//   abort      cancel the current job, return to IDLE
//   in_valid   operand source has a pair on the A/B register inputs
//   in_ready   sequencer accepts a pair
//   ld_ab      A/B register load enable (in_valid & in_ready)
//   acc_clr    synchronous accumulator clear
//   acc_en     accumulate enable
//   res_valid  accumulator holds the final job result
//   res_ready  consumer takes the result
//   busy       high in every state except IDLE
//   count      pairs accepted in the current job
module mac_sequencer #(
    parameter int CNT_W   = 8,
    parameter int MUL_LAT = 1
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ld_ab,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(MUL_LAT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_q, len_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [2:0]       drain_cnt, drain_nxt;
    logic [MUL_LAT-1:0] en_sr, en_sr_nxt;

    // in_ready is registered, so the load enable is only one AND gate deep.
    assign ld_ab = in_valid & in_ready;

    // Last tap of the delay line; already a flop, so acc_en is registered.
    assign acc_en = en_sr[MUL_LAT-1];

    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        count_nxt = count;
        drain_nxt = drain_cnt;

        en_sr_nxt    = '0;
        en_sr_nxt[0] = ld_ab;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            en_sr_nxt[i] = en_sr[i-1];
        end

        if (abort) begin
            // ld_ab can only be high in FEED; the pair is loaded this cycle,
            // so it still counts as accepted, but it never gets accumulated
            // because the delay line is flushed.
            state_nxt = IDLE;
            en_sr_nxt = '0;
            if (ld_ab) begin
                count_nxt = count + 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_nxt   = len;
                        count_nxt = '0;
                        state_nxt = CLEAR;
                    end
                end
                CLEAR: begin
                    state_nxt = (len_q == '0) ? DONE : FEED;
                end
                FEED: begin
                    if (ld_ab) begin
                        count_nxt = count + 1'b1;
                        if (count_nxt == len_q) begin
                            state_nxt = DRAIN;
                            drain_nxt = DRAIN_INIT;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state_nxt = DONE;
                    end else begin
                        drain_nxt = drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Moore outputs are decoded from the next state and registered, so they
    // change on the same edge as the state register.
    always_ff @(posedge CLK) begin
        if (R) begin
            state     <= IDLE;
            len_q     <= '0;
            count     <= '0;
            drain_cnt <= '0;
            en_sr     <= '0;
            in_ready  <= 1'b0;
            acc_clr   <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            count     <= count_nxt;
            drain_cnt <= drain_nxt;
            en_sr     <= en_sr_nxt;
            in_ready  <= (state_nxt == FEED);
            acc_clr   <= (state_nxt == CLEAR);
            res_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Testbench for mac_sequencer. Two instances run side by side on the same
// stimulus: one with CNT_W=8/MUL_LAT=1 and one with CNT_W=4/MUL_LAT=3.
// Each cycle, the outputs of both are compared against a timeline model that
// predicts output behaviour from job events: start cycle, accepted pairs,
// last-accept cycle, flushes and result handoff.
module tb_mac_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       R, start, abort, in_valid, res_ready;
    logic [7:0] len_a;
    logic [3:0] len_b;

    logic       ir_a, ld_a, clr_a, ae_a, rv_a, busy_a;
    logic [7:0] cnt_a;
    logic       ir_b, ld_b, clr_b, ae_b, rv_b, busy_b;
    logic [3:0] cnt_b;

    mac_sequencer #(.CNT_W(8), .MUL_LAT(1)) u_a (
        .CLK(CLK), .R(R), .start(start), .len(len_a), .abort(abort),
        .in_valid(in_valid), .in_ready(ir_a), .ld_ab(ld_a), .acc_clr(clr_a),
        .acc_en(ae_a), .res_valid(rv_a), .res_ready(res_ready),
        .busy(busy_a), .count(cnt_a)
    );

    mac_sequencer #(.CNT_W(4), .MUL_LAT(3)) u_b (
        .CLK(CLK), .R(R), .start(start), .len(len_b), .abort(abort),
        .in_valid(in_valid), .in_ready(ir_b), .ld_ab(ld_b), .acc_clr(clr_b),
        .acc_en(ae_b), .res_valid(rv_b), .res_ready(res_ready),
        .busy(busy_b), .count(cnt_b)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model, one slot per instance.
    int ml[2] = '{1, 3};
    bit act[2];
    int cnt_m[2], len_m[2], clr_c[2], feed_c[2], done_c[2], lf[2];
    bit ld_hist[2][4096];

    // One clock cycle: drive inputs after the rising edge, check on the
    // falling edge, then advance the model with this cycle's inputs.
    task automatic cycle(input bit r, input bit s, input int l,
                         input bit a, input bit v, input bit rr);
        logic [13:0] obs, exp_v;
        bit e_rdy, e_clr, e_rv, e_ld, e_ae;
        @(posedge CLK);
        #1;
        R         = r;
        start     = s;
        len_a     = 8'(l);
        len_b     = 4'(l);
        abort     = a;
        in_valid  = v;
        res_ready = rr;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            e_clr = act[k] && (cyc == clr_c[k]);
            e_rdy = act[k] && (cyc >= feed_c[k]) && (done_c[k] < 0)
                    && (cnt_m[k] < len_m[k]);
            e_rv  = act[k] && (done_c[k] >= 0) && (cyc >= done_c[k]);
            e_ld  = v && e_rdy;
            e_ae  = (cyc >= ml[k]) && ld_hist[k][cyc-ml[k]]
                    && (lf[k] < cyc - ml[k]);
            exp_v = {act[k], e_rdy, e_ld, e_clr, e_ae, e_rv, 8'(cnt_m[k])};
            if (k == 0)
                obs = {busy_a, ir_a, ld_a, clr_a, ae_a, rv_a, cnt_a};
            else
                obs = {busy_b, ir_b, ld_b, clr_b, ae_b, rv_b, 4'b0000, cnt_b};
            checks++;
            assert (obs === exp_v) else begin
                fails++;
                $error("FAIL dut%0d cycle %0d busy/rdy/ld/clr/en/rv/count: observed %b expected %b",
                       k, cyc, obs, exp_v);
            end

            ld_hist[k][cyc] = e_ld;
            if (r) begin
                act[k]   = 1'b0;
                cnt_m[k] = 0;
                lf[k]    = cyc;
            end else if (a) begin
                act[k] = 1'b0;
                if (e_ld) cnt_m[k]++;
                lf[k] = cyc;
            end else if (!act[k]) begin
                if (s) begin
                    act[k]    = 1'b1;
                    len_m[k]  = l;
                    cnt_m[k]  = 0;
                    clr_c[k]  = cyc + 1;
                    feed_c[k] = cyc + 2;
                    done_c[k] = (l == 0) ? cyc + 2 : -1;
                end
            end else begin
                if (e_ld) begin
                    cnt_m[k]++;
                    if (cnt_m[k] == len_m[k]) done_c[k] = cyc + ml[k] + 1;
                end
                if (e_rv && rr) act[k] = 1'b0;
            end
        end
        cyc++;
    endtask

    // A job starting at its cycle 0; optional abort/reset cycle, random
    // in_valid/res_ready densities and optional stray starts.
    task automatic job(input int l, input int n, input int ab_at, input int rs_at,
                       input int iv_pct, input int rr_pct, input bit noise);
        bit s, v, rr;
        int ll;
        for (int t = 0; t < n; t++) begin
            s  = (t == 0) || (noise && ($urandom_range(0, 3) == 0));
            ll = (t == 0) ? l : int'($urandom_range(0, 15));
            v  = ($urandom_range(0, 99) < iv_pct);
            rr = ($urandom_range(0, 99) < rr_pct);
            cycle(t == rs_at, s, ll, t == ab_at, v, rr);
        end
    endtask

    initial begin
        R = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        len_a = '0; len_b = '0;
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0; cnt_m[k] = 0; len_m[k] = 0; lf[k] = -1;
            clr_c[k] = -1; feed_c[k] = -1; done_c[k] = -1;
        end
        repeat (2) @(posedge CLK);

        // Reset state
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Basic job: len 4, in_valid and res_ready held high
        job(4, 12, -1, -1, 100, 100, 0);

        // Bubbles 1,0,1,0,1 from cycle 2, res_ready low until cycle 11
        for (int t = 0; t < 16; t++)
            cycle(0, t == 0, 3, 0,
                  (t < 2) ? 1'b0 : ((t < 7) ? ((t - 2) % 2 == 0) : 1'b1),
                  t >= 11);

        // Zero length
        job(0, 5, -1, -1, 100, 100, 0);

        // Abort mid-job at cycle 6 with len 10
        job(10, 12, 6, -1, 100, 100, 0);

        // Reset during DRAIN
        job(4, 12, -1, 6, 100, 100, 0);

        // Starts in FEED and DONE with a different len are ignored
        for (int t = 0; t < 16; t++)
            cycle(0, (t == 0) || (t == 4) || (t == 10), (t == 0) ? 5 : 9, 0, 1'b1, t >= 12);

        // Maximum length for the 4-bit instance
        job(15, 24, -1, -1, 100, 100, 0);

        // Randomized jobs with occasional aborts/resets and stray starts
        repeat (12) begin
            job(int'($urandom_range(0, 15)), 40,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : -1,
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 25)) : -1,
                70, 50, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control FSM for the MAC unit datapath. It runs one dot-product job of `len` operand pairs. For each job it pulses the accumulator clear, accepts operand pairs over a valid/ready handshake, and drives the load enable of the 8-bit A/B operand registers. Accumulator enables are delayed to match the multiplier latency. After the pipeline drains, the sequencer holds a result-valid handshake until the consumer takes the accumulator value. It sits between the operand source and the operand/accumulator register banks and contains no arithmetic datapath itself.

## Interface
- `CNT_W`, 8: width of `len` and `count`.
- `MUL_LAT`, 1: cycles from the operand-register load edge to a valid product at the accumulator input. Must be 1..4.

- `CLK`  in  1  clock; all logic is rising-edge.
- `R`  in  1  reset, synchronous and active-high.
- `start`  in  1  starts a job; honoured only in IDLE.
- `len`  in  CNT_W  number of operand pairs; sampled when `start` is honoured.
- `abort`  in  1  cancels the current job.
- `in_valid`  in  1  operand source has a pair on the A/B register inputs.
- `in_ready`  out  1  sequencer accepts a pair.
- `ld_ab`  out  1  load enable to the A/B 8-bit registers; equals `in_valid & in_ready`.
- `acc_clr`  out  1  synchronous clear to the accumulator register.
- `acc_en`  out  1  accumulate enable.
- `res_valid`  out  1  accumulator holds the final job result.
- `res_ready`  in  1  consumer takes the result.
- `busy`  out  1  high in every state except IDLE.
- `count`  out  CNT_W  pairs accepted in the current job.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- **IDLE**
  - All handshake outputs are 0.
  - On `start`: latch `len`, set `count`=0, go to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `acc_clr`=1.
  - Next state is DONE if the latched len = 0, otherwise FEED.
- **FEED**
  - `in_ready`=1.
  - Each handshake increments `count`.
  - When the handshake brings `count` to `len`, go to DRAIN the next cycle; `in_ready` is 0 from that cycle on.
- **acc_en pipeline**
  - `acc_en` = `ld_ab` delayed by `MUL_LAT` cycles, implemented as a shift register.
  - Gaps in `in_valid` produce matching gaps in `acc_en`.
- **DRAIN**
  - Lasts exactly `MUL_LAT` cycles, so the last pending `acc_en` fires inside DRAIN.
  - Then go to DONE.
- **DONE**
  - `res_valid`=1, held until `res_ready`=1.
  - On the `res_ready` cycle the result is transferred; go to IDLE next cycle.
  - `start` in the same cycle is ignored and must be re-issued in IDLE.
- `start` outside IDLE is ignored and `len` is not resampled.
- **abort**
  - In any state, go to IDLE next cycle.
  - Flush the `acc_en` shift register, deassert `in_ready` and `res_valid` next cycle, and leave `count` holding its value.
  - `abort` has priority over `start`, handshakes and `res_ready`. Only `R` has higher priority.
- `count` never exceeds `len` and does not wrap. The maximum job length is 2^CNT_W−1.
- **Reset**
  - Synchronous `R`=1 forces IDLE.
  - `in_ready`, `ld_ab`, `acc_clr`, `acc_en`, `res_valid`, `busy` = 0; `count`=0; shift register cleared.
  - Reset takes effect mid-job with the same result, and no `acc_en` pulse is emitted afterwards.

## Timing
- Cycle 0: `start` sampled. Cycle 1: CLEAR, `acc_clr`=1, `busy`=1. Cycle 2: FEED, `in_ready`=1.
- With `in_valid` held high and len = N ≥ 1:
  - Handshakes occur in cycles 2..N+1.
  - `acc_en` is high in cycles 2+MUL_LAT..N+1+MUL_LAT.
  - DRAIN covers cycles N+2..N+1+MUL_LAT.
  - `res_valid` rises in cycle N+2+MUL_LAT.
- With len = 0, `res_valid` rises in cycle 2.
- Each `in_valid` low cycle in FEED delays `res_valid` by one cycle.
- `acc_clr` and `acc_en` are never high in the same cycle.
- After the `res_ready` handshake in cycle T, IDLE is in T+1. The earliest next `start` is sampled in T+1.
- All outputs are registered except `ld_ab`, which is combinational from `in_valid` and the registered `in_ready`.

## Test plan
- **Basic job:** `len`=4, `MUL_LAT`=1, `in_valid` constant 1, `res_ready`=1 → `acc_clr` in cycle 1, `ld_ab` in cycles 2–5, `acc_en` in cycles 3–6, `res_valid` in cycle 7 only, IDLE in cycle 8, `count`=4.
- **Bubbles and backpressure:** `len`=3, `in_valid` pattern 1,0,1,0,1 from cycle 2, `res_ready` low for 3 cycles → `acc_en` mirrors `ld_ab` shifted by 1, `res_valid` held high 4 cycles with no extra `acc_en`.
- **Zero length:** `len`=0 → `acc_clr` in cycle 1, `res_valid` in cycle 2, no `ld_ab` or `acc_en`.
- **Abort mid-job:** `MUL_LAT`=3, `len`=10, `abort` in cycle 6 → IDLE in cycle 7, no `acc_en` from cycle 7 on, `count`=5.
- **Reset mid-job:** `R` asserted during DRAIN → every output 0 the next cycle. A `start` during DONE or FEED is ignored and `len` is not resampled.
- **Maximum length:** `CNT_W`=4, `len`=15 → exactly 15 handshakes, `count` stops at 15, `res_valid` in cycle 17+`MUL_LAT`.
